sia_rxq: RTL
============

# sia_rxq

Serial receive queue for the SIA (serial interface adapter); it is the receive-side counterpart of `sia_txq`. It samples an asynchronous serial line, deserializes frames of programmable length and baud rate, and queues them in a small FIFO for the host bus to pop. Frames are delivered in the same LSB-first, start-bit-at-bit-0 layout that `sia_txq` accepts. A frame sent by `sia_txq` therefore reads back bit-identical.

## Interface
- `SHIFT_REG_WIDTH`, 12: maximum frame length in bits, including start and stop bits.
- `BAUD_RATE_WIDTH`, 32: width of the baud divisor.
- `DEPTH_BITS`, 2: the FIFO holds 2^DEPTH_BITS frames.

Ports:
- `clk_i`  in  1  system clock; all logic is on the rising edge.
- `reset_i`  in  1  synchronous, active-low reset (0 = reset).
- `rxd_i`  in  1  asynchronous serial input; idle level is 1.
- `bits_i`  in  5  frame length in bits, including start and stop bits.
- `baud_i`  in  BAUD_RATE_WIDTH  bit period in clocks, minus 1.
- `dat_o`  out  SHIFT_REG_WIDTH  head of the FIFO (first-word fall-through).
- `re_i`  in  1  pop the FIFO head.
- `clr_i`  in  1  clear `overrun_o`.
- `rxc_o`  out  1  one-cycle pulse at every bit-sample instant.
- `empty_o`  out  1  FIFO holds no frames.
- `full_o`  out  1  FIFO holds 2^DEPTH_BITS frames.
- `idle_o`  out  1  receive engine is in IDLE.
- `overrun_o`  out  1  sticky flag: a completed frame was dropped.

## Operation
- `rxd_i` passes through a 2-flop synchronizer; the synchronized value is `rxs`. The previous value of `rxs` is also kept.
- Engine states:
  - IDLE: on a falling edge of `rxs` (previous 1, current 0), load the baud counter with `baud_i>>1`, clear the bit index, preset the shift register to all-ones, and go to START.
  - START: the counter decrements each cycle; when it reaches 0, sample the line.
    - If `rxs`=1, treat it as a false start: return to IDLE with no push and no `rxc_o` pulse.
    - Otherwise write `sr[0]`=0, pulse `rxc_o`, set the index to 1, reload the counter with `baud_i`, and go to DATA.
  - DATA: when the counter reaches 0, write `sr[index]`=`rxs`, pulse `rxc_o`, and reload the counter.
    - If index = `bits_eff`−1, push the frame and return to IDLE. The return happens mid stop bit, so the engine is ready for the next start edge.
    - Otherwise increment the index.
- `bits_eff` = min(`bits_i`, `SHIFT_REG_WIDTH`). Values below 2 are treated as 2.
- Register bits at index ≥ `bits_eff` remain 1.
- The stop bit is stored unchecked; software detects framing errors from it.
- `bits_i` and `baud_i` must be stable whenever `idle_o`=0; behaviour under a change mid-frame is undefined but must not hang the engine.
- FIFO behaviour:
  - A push when not full stores the frame.
  - A push when full drops the frame and sets `overrun_o`. The exception is a push and pop in the same cycle: both take effect and there is no overrun.
  - `re_i` while empty is ignored.
  - `dat_o` reads all-ones while empty.
- `overrun_o` clears on `clr_i`. If a clear and a new overrun occur in the same cycle, the overrun wins.
- Pointers are DEPTH_BITS+1 bits wide and wrap modulo 2^(DEPTH_BITS+1). `full_o` is asserted when the MSBs differ and the low bits are equal.
- Reset values: `empty_o`=1, `full_o`=0, `idle_o`=1, `overrun_o`=0, `rxc_o`=0, `dat_o`=all-ones. The synchronizer flops reset to 1.
- Reset mid-frame abandons the frame: nothing is pushed and the FIFO is emptied.

## Timing
- Start bit: let cycle T be the first cycle in which `rxs` is low. The start sample and its `rxc_o` pulse come (`baud_i>>1`)+1 cycles after T, at the middle of the start bit.
- Each later sample comes `baud_i`+1 cycles after the previous one.
- The push into the FIFO happens on the clock edge that samples the stop bit. `empty_o` falls and `dat_o` becomes valid in the following cycle.
- Pop: with `re_i` high at edge E, `dat_o` and the flags reflect the popped state after E.
- With `baud_i`=49 and `bits_i`=10, the stop-bit sample falls 25+9·50 = 475 cycles after T.

## Structure
- A shared package `sia_pkg` holds:
  - the state encodings (IDLE, START, DATA);
  - the bit-index width, `$clog2(SHIFT_REG_WIDTH)`.
- One sub-module, `sia_fifo`: a parameterized synchronous FWFT FIFO with push/pop/full/empty.
- The engine stays in `sia_rxq`.

## Test plan
All scenarios use `baud_i`=49 and `bits_i`=10 unless stated otherwise.
- Single frame: drive `rxd_i` with `12'b111_11101101_0` LSB-first at 50 clocks/bit.
  - `rxc_o` pulses 10 times.
  - `idle_o`=0 during the frame.
  - Afterwards `empty_o`=0 and `dat_o`=`12'hFDA`.
  - `re_i` then returns `empty_o` to 1 and `dat_o` to `12'hFFF`.
- False start: hold `rxd_i` low for 10 clocks, then high.
  - One `rxc_o` pulse does not occur, and `idle_o` returns to 1 after 25 cycles.
  - `empty_o` stays 1.
- Fill and overrun: send 5 back-to-back frames, values `n` = `12'hE00|(n<<1)` for n=1..5, with no pops.
  - After 4 frames, `full_o`=1 and `overrun_o`=0.
  - After the 5th, `overrun_o`=1.
  - Pops return frames 1..4 in order.
  - `clr_i` then clears `overrun_o`.
- Simultaneous push and pop while full: assert `re_i` on the edge that samples the stop bit of frame 5.
  - `overrun_o`=0 and `full_o` stays 1.
  - The FIFO holds frames 2..5.
- Short frame: `bits_i`=7, receive `7'b1_10110_0`.
  - `dat_o`=`12'hFEC`.
- Reset mid-frame: assert `reset_i`=0 during the data bits of a frame.
  - All outputs take their reset values.
  - No frame is pushed.
  - The next complete frame is received correctly.

Source files
------------

// File: rtl/sia_pkg.sv
// Shared definitions for the SIA serial blocks: receive engine state encoding
// and the bit-index width helper.
package sia_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2
  } rx_state_t;

  function automatic int idx_width(input int shift_reg_width);
    return (shift_reg_width < 2) ? 1 : $clog2(shift_reg_width);
  endfunction

endpackage

// File: rtl/sia_fifo.sv
// Synchronous first-word-fall-through FIFO with a sticky overrun flag.
// The read port shows all-ones while the FIFO is empty.
module sia_fifo #(
  parameter int WIDTH      = 12,
  parameter int DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             overrun
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] PTR_ONE = {{DEPTH_BITS{1'b0}}, 1'b1};

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH_BITS:0] wr_ptr;
  logic [DEPTH_BITS:0] rd_ptr;
  logic do_pop;
  logic do_push;
  logic drop;

  // A pop frees the slot a simultaneous push needs, so full+pop+push is no overrun.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[DEPTH_BITS] != rd_ptr[DEPTH_BITS]) &&
                   (wr_ptr[DEPTH_BITS-1:0] == rd_ptr[DEPTH_BITS-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign rdata   = empty ? {WIDTH{1'b1}} : mem[rd_ptr[DEPTH_BITS-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= {(DEPTH_BITS+1){1'b0}};
      rd_ptr  <= {(DEPTH_BITS+1){1'b0}};
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      // A new overrun takes priority over a clear in the same cycle.
      if (drop)     overrun <= 1'b1;
      else if (clr) overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_BITS-1:0]] <= wdata;
  end

endmodule

// File: rtl/sia_rxq.sv
// SIA serial receive queue: synchronizes rxd, samples each bit mid-period,
// assembles LSB-first frames and queues them in a FWFT FIFO.
module sia_rxq #(
  parameter int SHIFT_REG_WIDTH = 12,
  parameter int BAUD_RATE_WIDTH = 32,
  parameter int DEPTH_BITS      = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       rxd_i,
  input  logic [4:0]                 bits_i,
  input  logic [BAUD_RATE_WIDTH-1:0] baud_i,
  output logic [SHIFT_REG_WIDTH-1:0] dat_o,
  input  logic                       re_i,
  input  logic                       clr_i,
  output logic                       rxc_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       idle_o,
  output logic                       overrun_o
);

  import sia_pkg::*;

  localparam int IW = idx_width(SHIFT_REG_WIDTH);

  logic                       sync1;
  logic                       rxs;
  logic                       rxs_prev;
  logic                       fall;
  rx_state_t                  state;
  rx_state_t                  state_next;
  logic [BAUD_RATE_WIDTH-1:0] cnt;
  logic [BAUD_RATE_WIDTH-1:0] cnt_next;
  logic [IW-1:0]              idx;
  logic [IW-1:0]              idx_next;
  logic [IW-1:0]              last_idx;
  logic [SHIFT_REG_WIDTH-1:0] sr;
  logic [SHIFT_REG_WIDTH-1:0] sr_next;
  logic [4:0]                 bits_eff;
  logic                       push;
  logic                       rxc;
  logic                       rxc_next;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      sync1    <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      sync1    <= rxd_i;
      rxs      <= sync1;
      rxs_prev <= rxs;
    end
  end

  always_comb begin
    bits_eff = bits_i;
    if (bits_i > 5'(SHIFT_REG_WIDTH)) begin
      bits_eff = 5'(SHIFT_REG_WIDTH);
    end else if (bits_i < 5'd2) begin
      bits_eff = 5'd2;
    end else begin
      bits_eff = bits_i;
    end
  end

  assign fall     = rxs_prev & ~rxs;
  assign last_idx = IW'(bits_eff - 5'd1);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    sr_next    = sr;
    push       = 1'b0;
    rxc_next   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fall) begin
          cnt_next   = baud_i >> 1;
          idx_next   = {IW{1'b0}};
          sr_next    = {SHIFT_REG_WIDTH{1'b1}};
          state_next = ST_START;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt != {BAUD_RATE_WIDTH{1'b0}}) begin
          cnt_next = cnt - BAUD_RATE_WIDTH'(1);
        end else if (rxs) begin
          // Line went back high before mid start bit: glitch, not a frame.
          state_next = ST_IDLE;
        end else begin
          sr_next[0] = 1'b0;
          rxc_next   = 1'b1;
          idx_next   = IW'(1);
          cnt_next   = baud_i;
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt != {BAUD_RATE_WIDTH{1'b0}}) begin
          cnt_next = cnt - BAUD_RATE_WIDTH'(1);
        end else begin
          if (int'(idx) < SHIFT_REG_WIDTH) begin
            sr_next[idx] = rxs;
          end else begin
            sr_next = sr;
          end
          rxc_next = 1'b1;
          cnt_next = baud_i;
          // >= rather than == so a mid-frame bits_i change still ends the frame.
          if (idx >= last_idx) begin
            push       = 1'b1;
            state_next = ST_IDLE;
          end else begin
            idx_next = idx + IW'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state <= ST_IDLE;
      cnt   <= {BAUD_RATE_WIDTH{1'b0}};
      idx   <= {IW{1'b0}};
      sr    <= {SHIFT_REG_WIDTH{1'b1}};
      rxc   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      sr    <= sr_next;
      rxc   <= rxc_next;
    end
  end

  assign rxc_o  = rxc;
  assign idle_o = (state == ST_IDLE);

  sia_fifo #(
    .WIDTH      (SHIFT_REG_WIDTH),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_fifo (
    .clk     (clk_i),
    .rst_n   (reset_i),
    .push    (push),
    .pop     (re_i),
    .clr     (clr_i),
    .wdata   (sr_next),
    .rdata   (dat_o),
    .empty   (empty_o),
    .full    (full_o),
    .overrun (overrun_o)
  );

endmodule
